// File: rtl/icache_miss_controller.sv
// rtl/icache_miss_controller.sv - instruction-cache line miss tracker and L2 request arbiter
// Optional feature macro: ICACHE_MISS_MERGE_EN (merge misses to a line already outstanding).
module icache_miss_controller #(
   parameter  int STRANDS         = 4,
   parameter  int LINE_ADDR_WIDTH = 26,
   localparam int SW              = (STRANDS > 1) ? $clog2(STRANDS) : 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_miss_request,
   input  logic [SW-1:0]              i_miss_strand,
   input  logic [LINE_ADDR_WIDTH-1:0] i_miss_line_addr,
   output logic                       o_load_collision,
   output logic [STRANDS-1:0]         o_load_complete_strands,
   output logic                       o_fill_valid,
   output logic [LINE_ADDR_WIDTH-1:0] o_fill_line_addr,
   output logic                       o_l2_req_valid,
   output logic [LINE_ADDR_WIDTH-1:0] o_l2_req_addr,
   output logic [SW-1:0]              o_l2_req_id,
   input  logic                       i_l2_req_ready,
   input  logic                       i_l2_resp_valid,
   input  logic [SW-1:0]              i_l2_resp_id
);

   localparam logic [1:0] ST_FREE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ISSUED = 2'd2;

   logic [1:0]                 r_state [STRANDS];
   logic [LINE_ADDR_WIDTH-1:0] r_addr  [STRANDS];
   logic [STRANDS-1:0]         r_mask  [STRANDS];
   logic [SW-1:0]              r_rr_ptr;
   logic                       r_req_valid;
   logic [LINE_ADDR_WIDTH-1:0] r_req_addr;
   logic [SW-1:0]              r_req_id;
   logic                       r_fill_valid;
   logic [LINE_ADDR_WIDTH-1:0] r_fill_addr;
   logic [STRANDS-1:0]         r_fill_strands;

   logic [1:0]                 w_state_n [STRANDS];
   logic [LINE_ADDR_WIDTH-1:0] w_addr_n  [STRANDS];
   logic [STRANDS-1:0]         w_mask_n  [STRANDS];
   logic [STRANDS-1:0]         w_waiting;
   logic [STRANDS-1:0]         w_onehot;
   logic [STRANDS-1:0]         w_merge_vec;
   logic                       w_resp_hit;
   logic                       w_collision;
   logic                       w_illegal;
   logic                       w_miss_take;
   logic                       w_sel_found;
   logic [SW-1:0]              w_sel_idx;
   logic [SW-1:0]              w_rr_idx;
   logic [SW-1:0]              w_ptr_next;

   always_comb begin
      w_waiting = '0;
      for (int e = 0; e < STRANDS; e++) begin
         if (r_state[e] != ST_FREE) begin
            w_waiting = w_waiting | r_mask[e];
         end
      end
   end

   assign w_onehot    = {{(STRANDS-1){1'b0}}, 1'b1} << i_miss_strand;
   assign w_resp_hit  = i_l2_resp_valid && (r_state[i_l2_resp_id] == ST_ISSUED);
   // A miss to the line completing this cycle must retry rather than join the freeing entry.
   assign w_collision = i_miss_request && w_resp_hit &&
                        (i_miss_line_addr == r_addr[i_l2_resp_id]);
   assign w_illegal   = w_waiting[i_miss_strand];
   assign w_miss_take = i_miss_request && !w_collision && !w_illegal;

`ifdef ICACHE_MISS_MERGE_EN
   always_comb begin
      w_merge_vec = '0;
      for (int e = 0; e < STRANDS; e++) begin
         w_merge_vec[e] = (r_state[e] != ST_FREE) && (r_addr[e] == i_miss_line_addr);
      end
   end
`else
   assign w_merge_vec = '0;
`endif

   // Issue, completion and allocation always touch distinct entries.
   always_comb begin
      for (int e = 0; e < STRANDS; e++) begin
         w_state_n[e] = r_state[e];
         w_addr_n[e]  = r_addr[e];
         w_mask_n[e]  = r_mask[e];
      end
      if (r_req_valid && i_l2_req_ready) begin
         w_state_n[r_req_id] = ST_ISSUED;
      end
      if (w_resp_hit) begin
         w_state_n[i_l2_resp_id] = ST_FREE;
         w_mask_n[i_l2_resp_id]  = '0;
      end
      if (w_miss_take) begin
         if (|w_merge_vec) begin
            for (int e = 0; e < STRANDS; e++) begin
               if (w_merge_vec[e]) begin
                  w_mask_n[e] = r_mask[e] | w_onehot;
               end
            end
         end else begin
            w_state_n[i_miss_strand] = ST_WAIT;
            w_addr_n[i_miss_strand]  = i_miss_line_addr;
            w_mask_n[i_miss_strand]  = w_onehot;
         end
      end
   end

   always_comb begin
      w_sel_found = 1'b0;
      w_sel_idx   = '0;
      w_rr_idx    = '0;
      for (int k = 0; k < STRANDS; k++) begin
         w_rr_idx = SW'((int'(r_rr_ptr) + k) % STRANDS);
         if (!w_sel_found && (w_state_n[w_rr_idx] == ST_WAIT)) begin
            w_sel_found = 1'b1;
            w_sel_idx   = w_rr_idx;
         end
      end
      w_ptr_next = (w_sel_idx == SW'(STRANDS - 1)) ? '0 : w_sel_idx + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int e = 0; e < STRANDS; e++) begin
            r_state[e] <= ST_FREE;
            r_addr[e]  <= '0;
            r_mask[e]  <= '0;
         end
         r_rr_ptr       <= '0;
         r_req_valid    <= 1'b0;
         r_req_addr     <= '0;
         r_req_id       <= '0;
         r_fill_valid   <= 1'b0;
         r_fill_addr    <= '0;
         r_fill_strands <= '0;
      end else begin
         for (int e = 0; e < STRANDS; e++) begin
            r_state[e] <= w_state_n[e];
            r_addr[e]  <= w_addr_n[e];
            r_mask[e]  <= w_mask_n[e];
         end
         // A presented request holds until accepted; only then is the next one chosen.
         if (!r_req_valid || i_l2_req_ready) begin
            r_req_valid <= w_sel_found;
            if (w_sel_found) begin
               r_req_addr <= w_addr_n[w_sel_idx];
               r_req_id   <= w_sel_idx;
               r_rr_ptr   <= w_ptr_next;
            end
         end
         r_fill_valid   <= w_resp_hit;
         r_fill_strands <= w_resp_hit ? r_mask[i_l2_resp_id] : '0;
         if (w_resp_hit) begin
            r_fill_addr <= r_addr[i_l2_resp_id];
         end
      end
   end

   assign o_load_collision        = w_collision && !i_reset;
   assign o_load_complete_strands = r_fill_strands;
   assign o_fill_valid            = r_fill_valid;
   assign o_fill_line_addr        = r_fill_addr;
   assign o_l2_req_valid          = r_req_valid;
   assign o_l2_req_addr           = r_req_addr;
   assign o_l2_req_id             = r_req_id;

   a_legal_miss: assert property (@(posedge i_clk) disable iff (i_reset)
      i_miss_request |-> !w_illegal);
   a_resp_after_issue: assert property (@(posedge i_clk) disable iff (i_reset)
      i_l2_resp_valid |-> (r_state[i_l2_resp_id] != ST_WAIT));
   c_stale_resp: cover property (@(posedge i_clk) disable iff (i_reset)
      i_l2_resp_valid && (r_state[i_l2_resp_id] == ST_FREE));

endmodule
